dino_jump_ctrl: RTL and testbench

Frame-rate jump sequencer for the dino sprite. Turns the raw jump button and the obstacle collision flag into a registered vertical offset and game-state flags. Runs the jump arc in whole-frame steps so that jump speed does not depend on pixel-clock rate. Sits between the button input, the VGA timing generator's frame tick and the sprite renderer, which subtracts `jump_offset` from its base Y.

---
 rtl/dino_jump_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_dino_jump_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: frame-rate jump sequencer for the dino sprite.
// Synchronizes the jump button, runs the jump arc one step per video frame,
// and presents a registered vertical offset plus game-state flags.
module dino_jump_ctrl #(
    parameter int JUMP_HEIGHT   = 50,
    parameter int RISE_STEP     = 2,
    parameter int FALL_STEP     = 2,
    parameter int APEX_HOLD     = 4,
    parameter int BUFFER_FRAMES = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       jmp_btn,
    input  logic       collision,
    output logic [9:0] jump_offset,
    output logic       airborne,
    output logic       game_over,
    output logic       restart,
    output logic [7:0] jump_count
);

    localparam logic [9:0] HEIGHT_C     = 10'(JUMP_HEIGHT);
    localparam logic [9:0] RISE_C       = 10'(RISE_STEP);
    localparam logic [9:0] FALL_C       = 10'(FALL_STEP);
    localparam logic [7:0] HOLD_C       = 8'(APEX_HOLD);
    localparam logic [7:0] BUF_C        = 8'(BUFFER_FRAMES);
    // First rise step out of IDLE, clipped to the apex height.
    localparam logic [9:0] FIRST_STEP_C = (RISE_STEP < JUMP_HEIGHT) ? 10'(RISE_STEP)
                                                                     : 10'(JUMP_HEIGHT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RISE = 3'd1,
        ST_APEX = 3'd2,
        ST_FALL = 3'd3,
        ST_DEAD = 3'd4
    } state_t;

    // Button synchronizer and edge detector
    logic        sync1_r;
    logic        sync2_r;
    logic        btn_d_r;
    logic        press_r;

    // Sequencer state and next-state values
    state_t      state_r;
    state_t      state_s;
    logic [9:0]  offset_r;
    logic [9:0]  offset_s;
    logic        pending_r;
    logic        pending_s;
    logic [7:0]  hold_r;
    logic [7:0]  hold_s;
    logic [7:0]  buf_r;
    logic [7:0]  buf_s;
    logic [7:0]  count_r;
    logic [7:0]  count_s;

    // Arithmetic helpers
    logic [10:0] rise_sum_s;
    logic [9:0]  fall_off_s;

    // Output flag decode and registers
    logic        airborne_s;
    logic        game_over_s;
    logic        restart_s;
    logic        airborne_r;
    logic        game_over_r;
    logic        restart_r;

    // Two-flop synchronizer followed by a registered rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            btn_d_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            sync1_r <= jmp_btn;
            sync2_r <= sync1_r;
            btn_d_r <= sync2_r;
            press_r <= sync2_r & ~btn_d_r;
        end
    end

    // Sequencer state register, including the offset and bookkeeping counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            offset_r  <= 10'd0;
            pending_r <= 1'b0;
            hold_r    <= 8'd0;
            buf_r     <= 8'd0;
            count_r   <= 8'd0;
        end else begin
            state_r   <= state_s;
            offset_r  <= offset_s;
            pending_r <= pending_s;
            hold_r    <= hold_s;
            buf_r     <= buf_s;
            count_r   <= count_s;
        end
    end

    // Next-state logic: collision beats frame_tick, which beats press.
    always_comb begin
        state_s    = state_r;
        offset_s   = offset_r;
        pending_s  = pending_r;
        hold_s     = hold_r;
        buf_s      = buf_r;
        count_s    = count_r;
        // Rise sum is one bit wider so the apex compare never sees a wrap.
        rise_sum_s = {1'b0, offset_r} + {1'b0, RISE_C};
        // Fall saturates at ground instead of wrapping.
        fall_off_s = (offset_r < FALL_C) ? 10'd0 : (offset_r - FALL_C);

        case (state_r)
            ST_IDLE: begin
                if (collision) begin
                    state_s   = ST_DEAD;
                    pending_s = 1'b0;
                end else if (frame_tick && pending_r) begin
                    state_s   = ST_RISE;
                    pending_s = 1'b0;
                    count_s   = count_r + 8'd1;
                    offset_s  = FIRST_STEP_C;
                end else if (press_r) begin
                    pending_s = 1'b1;
                end else begin
                    pending_s = pending_r;
                end
            end

            ST_RISE: begin
                if (collision) begin
                    state_s   = ST_DEAD;
                    pending_s = 1'b0;
                end else if (frame_tick) begin
                    if (rise_sum_s >= {1'b0, HEIGHT_C}) begin
                        offset_s = HEIGHT_C;
                        if (HOLD_C == 8'd0) begin
                            state_s = ST_FALL;
                            hold_s  = 8'd0;
                        end else begin
                            state_s = ST_APEX;
                            hold_s  = HOLD_C;
                        end
                    end else begin
                        offset_s = rise_sum_s[9:0];
                    end
                end else begin
                    state_s = ST_RISE;
                end
            end

            ST_APEX: begin
                if (collision) begin
                    state_s   = ST_DEAD;
                    pending_s = 1'b0;
                end else if (frame_tick) begin
                    if (hold_r <= 8'd1) begin
                        state_s = ST_FALL;
                        hold_s  = 8'd0;
                    end else begin
                        hold_s  = hold_r - 8'd1;
                    end
                end else begin
                    state_s = ST_APEX;
                end
            end

            ST_FALL: begin
                if (collision) begin
                    state_s   = ST_DEAD;
                    pending_s = 1'b0;
                    buf_s     = 8'd0;
                end else begin
                    if (frame_tick) begin
                        offset_s = fall_off_s;
                        // The buffer window expires on the tick it reaches 0.
                        if (buf_r != 8'd0) begin
                            buf_s = buf_r - 8'd1;
                            if (buf_r == 8'd1) begin
                                pending_s = 1'b0;
                            end else begin
                                pending_s = pending_r;
                            end
                        end else begin
                            buf_s = buf_r;
                        end
                        if (fall_off_s == 10'd0) begin
                            buf_s = 8'd0;
                            // Buffered press relaunches at ground; first step on the next tick.
                            if (pending_s) begin
                                state_s   = ST_RISE;
                                pending_s = 1'b0;
                                count_s   = count_r + 8'd1;
                            end else begin
                                state_s   = ST_IDLE;
                            end
                        end else begin
                            state_s = ST_FALL;
                        end
                    end else begin
                        state_s = ST_FALL;
                    end
                    // A press already consumed by a same-tick relaunch is dropped.
                    if (press_r && (BUF_C != 8'd0) && (state_s != ST_RISE)) begin
                        pending_s = 1'b1;
                        buf_s     = (state_s == ST_FALL) ? BUF_C : 8'd0;
                    end else begin
                        pending_s = pending_s;
                    end
                end
            end

            ST_DEAD: begin
                if (press_r) begin
                    state_s   = ST_IDLE;
                    offset_s  = 10'd0;
                    pending_s = 1'b0;
                    hold_s    = 8'd0;
                    buf_s     = 8'd0;
                    count_s   = 8'd0;
                end else begin
                    state_s   = ST_DEAD;
                end
            end

            default: begin
                state_s   = ST_IDLE;
                offset_s  = 10'd0;
                pending_s = 1'b0;
                hold_s    = 8'd0;
                buf_s     = 8'd0;
                count_s   = 8'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so flags align with the offset.
    always_comb begin
        airborne_s  = 1'b0;
        game_over_s = 1'b0;
        restart_s   = (state_r == ST_DEAD) && (state_s == ST_IDLE);
        case (state_s)
            ST_RISE, ST_APEX, ST_FALL: begin
                airborne_s  = 1'b1;
                game_over_s = 1'b0;
            end
            ST_DEAD: begin
                airborne_s  = 1'b0;
                game_over_s = 1'b1;
            end
            default: begin
                airborne_s  = 1'b0;
                game_over_s = 1'b0;
            end
        endcase
    end

    // Registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            airborne_r  <= 1'b0;
            game_over_r <= 1'b0;
            restart_r   <= 1'b0;
        end else begin
            airborne_r  <= airborne_s;
            game_over_r <= game_over_s;
            restart_r   <= restart_s;
        end
    end

    assign jump_offset = offset_r;
    assign jump_count  = count_r;
    assign airborne    = airborne_r;
    assign game_over   = game_over_r;
    assign restart     = restart_r;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed testbench for dino_jump_ctrl: default-parameter instance plus a
// RISE_STEP=7 instance for the saturating-apex case.
module tb_dino_jump_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       jmp_btn = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] jump_offset;
    logic       airborne;
    logic       game_over;
    logic       restart;
    logic [7:0] jump_count;

    logic       tick7 = 1'b0;
    logic       btn7 = 1'b0;
    logic       coll7 = 1'b0;
    logic [9:0] off7;
    logic       air7;
    logic       go7;
    logic       rst7;
    logic [7:0] cnt7;

    int passes = 0;
    int total = 0;
    logic [7:0] exp_count = 8'd0;

    always #5 clk = ~clk;

    dino_jump_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .jmp_btn(jmp_btn),
        .collision(collision), .jump_offset(jump_offset), .airborne(airborne),
        .game_over(game_over), .restart(restart), .jump_count(jump_count)
    );

    dino_jump_ctrl #(.JUMP_HEIGHT(50), .RISE_STEP(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .frame_tick(tick7), .jmp_btn(btn7),
        .collision(coll7), .jump_offset(off7), .airborne(air7),
        .game_over(go7), .restart(rst7), .jump_count(cnt7)
    );

    task automatic tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic press(input bit which);
        @(negedge clk);
        if (which) btn7 = 1'b1; else jmp_btn = 1'b1;
        repeat (5) @(negedge clk);
        if (which) btn7 = 1'b0; else jmp_btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({jump_offset, airborne, game_over, restart, jump_count} !== 21'd0)
            $display("FAIL reset: got off=%0d air=%b go=%b rs=%b cnt=%0d, want all 0",
                     jump_offset, airborne, game_over, restart, jump_count);
        else passes++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_jump();
        press(1'b0);
        total++;
        if ({jump_offset, airborne} !== {10'd0, 1'b0})
            $display("FAIL press_no_tick: got off=%0d air=%b, want 0/0", jump_offset, airborne);
        else passes++;
        exp_count++;
        for (int i = 1; i <= 25; i++) begin
            tick();
            total++;
            if ({jump_offset, airborne} !== {10'(2 * i), 1'b1})
                $display("FAIL rise[%0d]: got off=%0d air=%b, want %0d/1", i, jump_offset, airborne, 2 * i);
            else passes++;
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if ({jump_offset, airborne} !== {10'd50, 1'b1})
                $display("FAIL apex[%0d]: got off=%0d air=%b, want 50/1", i, jump_offset, airborne);
            else passes++;
        end
        for (int i = 1; i <= 25; i++) begin
            tick();
            total++;
            if ({jump_offset, airborne} !== {10'(50 - 2 * i), (i < 25)})
                $display("FAIL fall[%0d]: got off=%0d air=%b, want %0d/%0d",
                         i, jump_offset, airborne, 50 - 2 * i, (i < 25));
            else passes++;
        end
        total++;
        if (jump_count !== exp_count)
            $display("FAIL count_after_jump: got %0d, want %0d", jump_count, exp_count);
        else passes++;
        tick();
        total++;
        if ({jump_offset, airborne} !== {10'd0, 1'b0})
            $display("FAIL idle_after_land: got off=%0d air=%b, want 0/0", jump_offset, airborne);
        else passes++;
    endtask

    task automatic test_buffered_press();
        // Press at offset 10: buffer survives the 5 ticks to ground.
        press(1'b0);
        exp_count++;
        ticks(29 + 20);
        total++;
        if (jump_offset !== 10'd10)
            $display("FAIL buf_setup10: got off=%0d, want 10", jump_offset);
        else passes++;
        press(1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if ({jump_offset, airborne} !== {10'(10 - 2 * i), 1'b1})
                $display("FAIL buf_fall10[%0d]: got off=%0d air=%b, want %0d/1",
                         i, jump_offset, airborne, 10 - 2 * i);
            else passes++;
        end
        exp_count++;
        total++;
        if (jump_count !== exp_count)
            $display("FAIL buf_relaunch_count: got %0d, want %0d", jump_count, exp_count);
        else passes++;
        tick();
        total++;
        if ({jump_offset, airborne} !== {10'd2, 1'b1})
            $display("FAIL buf_first_step: got off=%0d air=%b, want 2/1", jump_offset, airborne);
        else passes++;
        ticks(24 + 4 + 25);
        total++;
        if ({jump_offset, airborne} !== {10'd0, 1'b0})
            $display("FAIL buf_land_idle: got off=%0d air=%b, want 0/0", jump_offset, airborne);
        else passes++;
        // Press at offset 20: buffer expires before landing.
        press(1'b0);
        exp_count++;
        ticks(29 + 15);
        total++;
        if (jump_offset !== 10'd20)
            $display("FAIL buf_setup20: got off=%0d, want 20", jump_offset);
        else passes++;
        press(1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if ({jump_offset, airborne} !== {10'(20 - 2 * i), (i < 10)})
                $display("FAIL buf_fall20[%0d]: got off=%0d air=%b, want %0d/%0d",
                         i, jump_offset, airborne, 20 - 2 * i, (i < 10));
            else passes++;
        end
        ticks(2);
        total++;
        if ({jump_offset, airborne, jump_count} !== {10'd0, 1'b0, exp_count})
            $display("FAIL buf_expired: got off=%0d air=%b cnt=%0d, want 0/0/%0d",
                     jump_offset, airborne, jump_count, exp_count);
        else passes++;
    endtask

    task automatic test_ignored_press();
        press(1'b0);
        exp_count++;
        ticks(5);
        press(1'b0);
        ticks(21);
        total++;
        if ({jump_offset, airborne} !== {10'd50, 1'b1})
            $display("FAIL ign_apex: got off=%0d air=%b, want 50/1", jump_offset, airborne);
        else passes++;
        press(1'b0);
        ticks(3 + 25);
        total++;
        if ({jump_offset, airborne, jump_count} !== {10'd0, 1'b0, exp_count})
            $display("FAIL ign_land: got off=%0d air=%b cnt=%0d, want 0/0/%0d",
                     jump_offset, airborne, jump_count, exp_count);
        else passes++;
        ticks(2);
        total++;
        if ({jump_offset, airborne, jump_count} !== {10'd0, 1'b0, exp_count})
            $display("FAIL ign_no_pending: got off=%0d air=%b cnt=%0d, want 0/0/%0d",
                     jump_offset, airborne, jump_count, exp_count);
        else passes++;
    endtask

    task automatic test_collision();
        press(1'b0);
        exp_count++;
        ticks(15);
        total++;
        if (jump_offset !== 10'd30)
            $display("FAIL coll_setup: got off=%0d, want 30", jump_offset);
        else passes++;
        @(negedge clk); collision = 1'b1; frame_tick = 1'b1;
        @(negedge clk); collision = 1'b0; frame_tick = 1'b0;
        total++;
        if ({jump_offset, airborne, game_over} !== {10'd30, 1'b0, 1'b1})
            $display("FAIL coll_enter: got off=%0d air=%b go=%b, want 30/0/1",
                     jump_offset, airborne, game_over);
        else passes++;
        ticks(3);
        @(negedge clk); collision = 1'b1;
        repeat (2) @(negedge clk);
        collision = 1'b0;
        ticks(2);
        total++;
        if ({jump_offset, airborne, game_over, jump_count} !== {10'd30, 1'b0, 1'b1, exp_count})
            $display("FAIL coll_frozen: got off=%0d air=%b go=%b cnt=%0d, want 30/0/1/%0d",
                     jump_offset, airborne, game_over, jump_count, exp_count);
        else passes++;
    endtask

    task automatic test_restart();
        int hits = 0;
        int first_at = 0;
        logic [18:0] snap = '1;
        @(negedge clk); jmp_btn = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (restart === 1'b1) begin
                hits++;
                if (first_at == 0) begin
                    first_at = i;
                    snap = {jump_offset, game_over, jump_count};
                end
            end
            frame_tick = (i % 3 == 0);
        end
        frame_tick = 1'b0;
        @(negedge clk);
        exp_count = 8'd0;
        total++;
        if (hits !== 1)
            $display("FAIL restart_pulses: got %0d, want 1", hits);
        else passes++;
        total++;
        if (first_at !== 4)
            $display("FAIL restart_latency: got cycle %0d, want 4", first_at);
        else passes++;
        total++;
        if (snap !== 19'd0)
            $display("FAIL restart_outputs: got off/go/cnt=%h, want 0", snap);
        else passes++;
        total++;
        if ({jump_offset, airborne, game_over, jump_count} !== 20'd0)
            $display("FAIL restart_held: got off=%0d air=%b go=%b cnt=%0d, want 0/0/0/0",
                     jump_offset, airborne, game_over, jump_count);
        else passes++;
        jmp_btn = 1'b0;
        repeat (4) @(negedge clk);
        ticks(2);
        total++;
        if ({jump_offset, airborne} !== {10'd0, 1'b0})
            $display("FAIL restart_release: got off=%0d air=%b, want 0/0", jump_offset, airborne);
        else passes++;
    endtask

    task automatic test_rise_step7();
        logic [9:0] exp;
        press(1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); tick7 = 1'b1;
            @(negedge clk); tick7 = 1'b0;
            exp = (i < 8) ? 10'(7 * i) : 10'd50;
            total++;
            if ({off7, air7, go7, rst7} !== {exp, 1'b1, 1'b0, 1'b0})
                $display("FAIL rise7[%0d]: got off=%0d air=%b go=%b rs=%b, want %0d/1/0/0",
                         i, off7, air7, go7, rst7, exp);
            else passes++;
        end
        total++;
        if (cnt7 !== 8'd1)
            $display("FAIL rise7_count: got %0d, want 1", cnt7);
        else passes++;
    endtask

    task automatic test_async_reset();
        press(1'b0);
        exp_count++;
        ticks(29 + 13);
        total++;
        if ({jump_offset, airborne} !== {10'd24, 1'b1})
            $display("FAIL arst_setup: got off=%0d air=%b, want 24/1", jump_offset, airborne);
        else passes++;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({jump_offset, airborne, game_over, restart, jump_count} !== 21'd0)
            $display("FAIL arst_async: got off=%0d air=%b go=%b rs=%b cnt=%0d, want all 0",
                     jump_offset, airborne, game_over, restart, jump_count);
        else passes++;
        @(negedge clk); rst_n = 1'b1;
        exp_count = 8'd0;
        ticks(3);
        total++;
        if ({jump_offset, airborne, jump_count} !== {10'd0, 1'b0, 8'd0})
            $display("FAIL arst_idle: got off=%0d air=%b cnt=%0d, want 0/0/0",
                     jump_offset, airborne, jump_count);
        else passes++;
        press(1'b0);
        tick();
        total++;
        if ({jump_offset, airborne, jump_count} !== {10'd2, 1'b1, 8'd1})
            $display("FAIL arst_new_jump: got off=%0d air=%b cnt=%0d, want 2/1/1",
                     jump_offset, airborne, jump_count);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_full_jump();
        test_buffered_press();
        test_ignored_press();
        test_collision();
        test_restart();
        test_rise_step7();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
